fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 10 +
 rtl/fetch_unit_pc_register.sv | 23 ++
 rtl/fetch_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, PC stride, NOP word.
package fetch_unit_pkg;
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] NOP    = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program counter with asynchronous reset to RESET_PC and a load enable.
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);
  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = en ? d : pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign q = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one request per cycle, buffers a returned word while
// the pipeline is stalled, and redirects on branch/jump with an IF/ID flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Write,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_target,
  input  logic        Jump,
  input  logic [31:0] Jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PC_out,
  output logic [31:0] instruction_out,
  output logic        fetch_valid,
  output logic        IF_Flush,
  output logic [15:0] imem_wait_cnt
);
  fetch_state_e state_q, state_d;
  logic [31:0]  buf_q, buf_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [31:0]  pc, pc_plus4, pc_nxt, tgt;
  logic         pc_en, redirect;

  assign redirect = Branch_taken | Jump;
  assign tgt      = Branch_taken ? Branch_target : Jump_target;
  assign pc_plus4 = pc + PC_INC;

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk (clk),
    .rst (reset),
    .en  (pc_en),
    .d   (pc_nxt),
    .q   (pc)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    pc_en   = 1'b0;
    pc_nxt  = pc_plus4;
    // A cycle in FETCH without ready counts as waiting, even if redirected.
    if (state_q == FETCH && !imem_ready && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
    if (redirect) begin
      pc_en   = 1'b1;
      pc_nxt  = tgt & ~32'd3;
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: if (imem_ready) begin
          if (PC_Write) pc_en = 1'b1;
          else begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end
        end
        HOLD: if (PC_Write) begin
          pc_en   = 1'b1;
          state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      buf_q   <= NOP;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs are forced quiet while reset is held.
  assign imem_req        = !reset && state_q == FETCH;
  assign imem_addr       = pc;
  assign PC_out          = pc_plus4;
  assign instruction_out = (state_q == HOLD) ? buf_q : imem_rdata;
  assign fetch_valid     = !reset && !redirect && (state_q == HOLD || imem_ready);
  assign IF_Flush        = !reset && redirect;
  assign imem_wait_cnt   = cnt_q;
endmodule
